// File: rtl/ballot_issue_console.sv
// Voter console: arms one ballot per ISSUE edge, drives ENABLE/VOTE_IN
// of a counting machine, times out abandoned ballots, counts votes.
module ballot_issue_console #(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ISSUE,
  input  logic             BTN_A,
  input  logic             BTN_B,
  input  logic             BTN_C,
  input  logic             ADMIN_RESET,
  output logic             ENABLE_OUT,
  output logic [1:0]       VOTE_OUT,
  output logic             BUSY,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] BALLOTS_ISSUED,
  output logic [2:0]       state
);

  localparam int TMAX =
    (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ARMED = 3'b001,
    CAST  = 3'b010,
    GAP   = 3'b011,
    ABORT = 3'b100,
    LOCK  = 3'b101
  } state_t;

  state_t        cur;
  logic [TW-1:0] timer;
  logic          issue_q;
  logic          clean;
  logic [2:0]    btns;
  logic          any_btn;
  logic          one_hot;
  logic [1:0]    pick;

  assign state   = cur;
  assign btns    = {BTN_C, BTN_B, BTN_A};
  assign any_btn = |btns;

  always_comb begin
    pick    = 2'b00;
    one_hot = 1'b1;
    case (btns)
      3'b001:  pick = 2'b01;
      3'b010:  pick = 2'b10;
      3'b100:  pick = 2'b11;
      default: one_hot = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET || ADMIN_RESET) begin
      cur            <= IDLE;
      ENABLE_OUT     <= 1'b0;
      VOTE_OUT       <= 2'b00;
      BUSY           <= 1'b0;
      TIMEOUT        <= 1'b0;
      BALLOTS_ISSUED <= '0;
      timer          <= '0;
      issue_q        <= 1'b0;
      clean          <= 1'b0;
    end else begin
      issue_q <= ISSUE;
      TIMEOUT <= 1'b0;
      case (cur)
        IDLE: begin
          if (ISSUE && !issue_q) begin
            cur        <= ARMED;
            ENABLE_OUT <= 1'b1;
            BUSY       <= 1'b1;
            timer      <= '0;
            clean      <= 1'b0;
          end
        end
        ARMED: begin
          timer <= timer + 1'b1;
          // buttons held since before arming never count
          if (!any_btn)
            clean <= 1'b1;
          if (clean && one_hot) begin
            cur      <= CAST;
            VOTE_OUT <= pick;
            timer    <= '0;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            cur        <= ABORT;
            ENABLE_OUT <= 1'b0;
            TIMEOUT    <= 1'b1;
          end
        end
        CAST: begin
          if (timer == TW'(HOLD_CYCLES - 1)) begin
            cur      <= GAP;
            VOTE_OUT <= 2'b00;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          cur        <= LOCK;
          ENABLE_OUT <= 1'b0;
          if (BALLOTS_ISSUED != CNT_MAX)
            BALLOTS_ISSUED <= BALLOTS_ISSUED + 1'b1;
        end
        ABORT: cur <= LOCK;
        LOCK: begin
          if (!ISSUE && !any_btn) begin
            cur  <= IDLE;
            BUSY <= 1'b0;
          end
        end
        default: begin
          cur        <= IDLE;
          ENABLE_OUT <= 1'b0;
          VOTE_OUT   <= 2'b00;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_issue_console.sv
// Bench for ballot_issue_console: directed scenarios plus random
// traffic, every cycle compared against a phase-level reference model.
module tb_ballot_issue_console;

  localparam int HOLD = 2;
  localparam int TOUT = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_CAST  = 2;
  localparam int P_GAP   = 3;
  localparam int P_ABORT = 4;
  localparam int P_LOCK  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue, btn_a, btn_b, btn_c, admin;
  logic          enable_out;
  logic [1:0]    vote_out;
  logic          busy, timeout;
  logic [CW-1:0] ballots;
  logic [2:0]    st;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int m_phase, m_left, m_age, m_code, m_count;
  bit m_clean, m_prev;

  ballot_issue_console #(
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W(CW)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .ISSUE(issue),
    .BTN_A(btn_a),
    .BTN_B(btn_b),
    .BTN_C(btn_c),
    .ADMIN_RESET(admin),
    .ENABLE_OUT(enable_out),
    .VOTE_OUT(vote_out),
    .BUSY(busy),
    .TIMEOUT(timeout),
    .BALLOTS_ISSUED(ballots),
    .state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int state_code(input int p);
    case (p)
      P_IDLE:  return 0;
      P_ARMED: return 1;
      P_CAST:  return 2;
      P_GAP:   return 3;
      P_ABORT: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic model_clock();
    int nb;
    nb = int'(btn_a) + int'(btn_b) + int'(btn_c);
    if (!rst_n || admin) begin
      m_phase = P_IDLE; m_clean = 0; m_prev = 0;
      m_count = 0; m_age = 0; m_code = 0;
      return;
    end
    case (m_phase)
      P_IDLE:
        if (issue && !m_prev) begin
          m_phase = P_ARMED; m_age = 0; m_clean = 0;
        end
      P_ARMED: begin
        if (m_clean && nb == 1) begin
          m_phase = P_CAST; m_left = HOLD;
          m_code = btn_a ? 1 : (btn_b ? 2 : 3);
        end else if (m_age == TOUT - 1) begin
          m_phase = P_ABORT;
        end else begin
          m_age++;
        end
        if (nb == 0) m_clean = 1;
      end
      P_CAST: begin
        m_left--;
        if (m_left == 0) m_phase = P_GAP;
      end
      P_GAP: begin
        if (m_count < CMAX) m_count++;
        m_phase = P_LOCK;
      end
      P_ABORT: m_phase = P_LOCK;
      default:
        if (!issue && nb == 0) m_phase = P_IDLE;
    endcase
    m_prev = issue;
  endtask

  task automatic compare_all();
    bit en;
    en = (m_phase == P_ARMED || m_phase == P_CAST || m_phase == P_GAP);
    chk("enable", int'(enable_out), int'(en));
    chk("vote", int'(vote_out), (m_phase == P_CAST) ? m_code : 0);
    chk("busy", int'(busy), int'(m_phase != P_IDLE));
    chk("timeout", int'(timeout), int'(m_phase == P_ABORT));
    chk("count", int'(ballots), m_count);
    chk("state", int'(st), state_code(m_phase));
    if (vote_out != 2'b00)
      chk("vote_needs_en", int'(enable_out), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit i, input bit a, input bit b, input bit c);
    issue = i; btn_a = a; btn_b = b; btn_c = c;
  endtask

  task automatic do_vote(input bit a, input bit b, input bit c);
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    drive(0, a, b, c); step();
    drive(0, 0, 0, 0);
    repeat (6) step();
  endtask

  int pulses;
  int base;
  int r;

  initial begin
    rst_n = 0; admin = 0;
    drive(0, 0, 0, 0);
    repeat (2) step();
    rst_n = 1;
    chk("reset_state", int'(st), 0);
    chk("reset_count", int'(ballots), 0);

    // button with no ballot issued
    drive(0, 1, 0, 0);
    repeat (4) step();
    chk("noissue_en", int'(enable_out), 0);
    drive(0, 0, 0, 0); step();

    // single vote for B, checked cycle by cycle
    drive(1, 0, 0, 0); step();
    chk("arm_en", int'(enable_out), 1);
    drive(0, 0, 0, 0); step();
    drive(0, 0, 1, 0); step();
    chk("b_code1", int'(vote_out), 2);
    drive(0, 0, 0, 0); step();
    chk("b_code2", int'(vote_out), 2);
    step();
    chk("gap_vote", int'(vote_out), 0);
    chk("gap_en", int'(enable_out), 1);
    step();
    chk("post_en", int'(enable_out), 0);
    chk("post_count", int'(ballots), 1);
    chk("post_lock", int'(st), 5);
    step();
    chk("back_idle", int'(st), 0);

    // multi-press ignored, then C alone
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    drive(0, 1, 0, 1); repeat (3) step();
    chk("multi_no_vote", int'(vote_out), 0);
    drive(0, 0, 0, 1); step();
    chk("c_code", int'(vote_out), 3);
    drive(0, 0, 0, 0); repeat (5) step();
    chk("multi_count", int'(ballots), 2);

    // abandoned ballot
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0);
    pulses = 0;
    repeat (20) begin
      step();
      if (timeout) pulses++;
    end
    chk("to_pulses", pulses, 1);
    chk("to_count", int'(ballots), 2);
    drive(0, 1, 0, 0); repeat (3) step();
    chk("to_no_vote", int'(vote_out), 0);
    drive(0, 0, 0, 0); step();

    // A held across the issue edge
    drive(1, 1, 0, 0); step();
    drive(0, 1, 0, 0); repeat (3) step();
    chk("held_no_vote", int'(vote_out), 0);
    drive(0, 0, 0, 0); step();
    drive(0, 1, 0, 0); step();
    chk("repress_vote", int'(vote_out), 1);

    // admin abort mid-cast
    admin = 1; step();
    admin = 0;
    chk("admin_state", int'(st), 0);
    chk("admin_count", int'(ballots), 0);
    drive(0, 0, 0, 0); step();

    // saturation
    repeat (17) do_vote(1, 0, 0);
    chk("saturate", int'(ballots), CMAX);

    // random traffic
    admin = 1; step(); admin = 0;
    base = n_tests;
    repeat (1500) begin
      r = $urandom_range(0, 9);
      issue = ($urandom_range(0, 3) == 0);
      btn_a = (r == 6); btn_b = (r == 7); btn_c = (r == 8);
      if (r == 9) {btn_c, btn_b, btn_a} = 3'($urandom_range(0, 7));
      admin = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1; admin = 0;
    chk("random_ran", int'(n_tests > base), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
